// File: rtl/lsu_pkg.sv
// Shared LSU types: funct3 encodings, FSM state, captured request and access-size helper.
`ifndef MEM_DEPTH
`define MEM_DEPTH 524288
`endif

package lsu_pkg;

  localparam int LSU_AWIDTH = 32;
  localparam int LSU_DWIDTH = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_e;

  typedef struct packed {
    logic                  we;
    logic [LSU_AWIDTH-1:0] addr;
    logic [LSU_DWIDTH-1:0] wdata;
    logic [2:0]            funct3;
  } lsu_req_t;

  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero-extends little-endian assembled split-load bytes per the original load funct3; combinational.
// Only built with LSU_MISALIGN_SPLIT_EN, the one configuration that instantiates it.
`ifdef LSU_MISALIGN_SPLIT_EN
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] raw,
  input  logic [2:0]        funct3,
  output logic [DWIDTH-1:0] result
);

  always_comb begin
    case (funct3)
      F3_LB:   result = {{(DWIDTH-8){raw[7]}}, raw[7:0]};
      F3_LH:   result = {{(DWIDTH-16){raw[15]}}, raw[15:0]};
      F3_LBU:  result = {{(DWIDTH-8){1'b0}}, raw[7:0]};
      F3_LHU:  result = {{(DWIDTH-16){1'b0}}, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule
`endif

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one request per handshake, 1 access cycle (size cycles when split), response held until taken.
// LSU_MISALIGN_SPLIT_EN splits misaligned in-range H/W accesses into byte beats; otherwise they are errors.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int                 AWIDTH    = 32,
  parameter int                 DWIDTH    = 32,
  parameter logic [AWIDTH-1:0]  BASE_ADDR = 32'h0100_0000,
  parameter int unsigned        MEM_BYTES = `MEM_DEPTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  input  logic [2:0]        req_funct3_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DWIDTH-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic [2:0]        mem_funct3_o,
  output logic              mem_memren_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  output logic              busy_o
);

  lsu_state_e        state;
  lsu_req_t          req_q;
  logic [2:0]        in_size;
  logic              in_illegal, in_misalign, in_range_err, in_err;
  logic [AWIDTH:0]   in_end, mem_limit;
  logic [DWIDTH-1:0] load_rdata;

  // Range math is one bit wider so an access wrapping past 2^AWIDTH lands above the limit.
  always_comb begin
    in_size      = size_of(req_funct3_i);
    in_illegal   = req_we_i ? (req_funct3_i >= 3'b011)
                            : (req_funct3_i == 3'b011 || req_funct3_i[2:1] == 2'b11);
    in_misalign  = (in_size == 3'd2 && req_addr_i[0]) ||
                   (in_size == 3'd4 && req_addr_i[1:0] != 2'b00);
    in_end       = {1'b0, req_addr_i} + (AWIDTH+1)'(in_size);
    mem_limit    = {1'b0, BASE_ADDR} + (AWIDTH+1)'(MEM_BYTES);
    in_range_err = (req_addr_i < BASE_ADDR) || (in_end > mem_limit);
`ifdef LSU_MISALIGN_SPLIT_EN
    in_err       = in_illegal || in_range_err;
`else
    in_err       = in_illegal || in_range_err || in_misalign;
`endif
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  logic              split_q;
  logic [1:0]        beat_q, beat_nxt, beat_last;
  logic [DWIDTH-1:0] asm_q, asm_nxt, split_rdata;

  always_comb begin
    beat_nxt  = beat_q + 2'd1;
    beat_last = 2'(size_of(req_q.funct3) - 3'd1);
    asm_nxt   = asm_q | (DWIDTH'(mem_data_i[7:0]) << {beat_q, 3'b000});
  end

  lsu_load_extend #(.DWIDTH(DWIDTH)) u_load_extend (
    .raw    (asm_nxt),
    .funct3 (req_q.funct3),
    .result (split_rdata)
  );

  assign load_rdata = split_q ? split_rdata : mem_data_i;
`else
  logic unused_req;
  assign unused_req = ^{req_q.addr, req_q.wdata, req_q.funct3};
  assign load_rdata = mem_data_i;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      req_q          <= '0;
      req_ready_o    <= 1'b1;
      resp_valid_o   <= 1'b0;
      resp_rdata_o   <= '0;
      resp_err_o     <= 1'b0;
      mem_addr_o     <= '0;
      mem_data_o     <= '0;
      mem_funct3_o   <= '0;
      mem_memren_o   <= 1'b0;
      mem_write_en_o <= 1'b0;
      busy_o         <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q        <= 1'b0;
      beat_q         <= '0;
      asm_q          <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          req_q       <= '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i, funct3: req_funct3_i};
          req_ready_o <= 1'b0;
          busy_o      <= 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
          split_q     <= in_misalign;
          beat_q      <= '0;
          asm_q       <= '0;
`endif
          if (in_err) begin
            state        <= RESP;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b1;
            resp_rdata_o <= '0;
          end else begin
            state          <= ACCESS;
            mem_addr_o     <= req_addr_i;
            mem_memren_o   <= !req_we_i;
            mem_write_en_o <= req_we_i;
`ifdef LSU_MISALIGN_SPLIT_EN
            if (in_misalign) begin
              mem_funct3_o <= req_we_i ? F3_SB : F3_LBU;
              mem_data_o   <= DWIDTH'(req_wdata_i[7:0]);
            end else
`endif
            begin
              mem_funct3_o <= req_funct3_i;
              mem_data_o   <= req_wdata_i;
            end
          end
        end
        ACCESS: begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (split_q && beat_q != beat_last) begin
            beat_q     <= beat_nxt;
            asm_q      <= asm_nxt;
            mem_addr_o <= req_q.addr + AWIDTH'(beat_nxt);
            mem_data_o <= DWIDTH'(req_q.wdata[{beat_nxt, 3'b000} +: 8]);
          end else
`endif
          begin
            state          <= RESP;
            mem_addr_o     <= '0;
            mem_data_o     <= '0;
            mem_funct3_o   <= '0;
            mem_memren_o   <= 1'b0;
            mem_write_en_o <= 1'b0;
            resp_valid_o   <= 1'b1;
            resp_err_o     <= 1'b0;
            resp_rdata_o   <= req_q.we ? '0 : load_rdata;
          end
        end
        RESP: if (resp_ready_i) begin
          state        <= IDLE;
          resp_valid_o <= 1'b0;
          resp_err_o   <= 1'b0;
          resp_rdata_o <= '0;
          busy_o       <= 1'b0;
          req_ready_o  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
